// File: rtl/adsr_envelope_pkg.sv
// Shared definitions for the ADSR envelope generator: state encodings and default widths.
package adsr_envelope_pkg;

  localparam int unsigned ENV_ACC_W  = 16;
  localparam int unsigned ENV_LVL_W  = 7;
  localparam int unsigned ENV_RATE_W = 8;

  typedef logic [2:0] env_state_t;

  localparam env_state_t ENV_IDLE    = 3'd0;
  localparam env_state_t ENV_ATTACK  = 3'd1;
  localparam env_state_t ENV_DECAY   = 3'd2;
  localparam env_state_t ENV_SUSTAIN = 3'd3;
  localparam env_state_t ENV_RELEASE = 3'd4;

  // States in which a note_off moves the envelope into release.
  function automatic logic env_gated(input env_state_t state);
    return (state == ENV_ATTACK) || (state == ENV_DECAY) || (state == ENV_SUSTAIN);
  endfunction

endpackage

// File: rtl/adsr_envelope_if.sv
// Control and level bundle between the voice allocator and one ADSR envelope.
interface adsr_envelope_if
  import adsr_envelope_pkg::*;
#(
  parameter int unsigned LVL_W  = ENV_LVL_W,
  parameter int unsigned RATE_W = ENV_RATE_W
);

  logic              sample_rate;
  logic              note_on;
  logic              note_off;
  logic [RATE_W-1:0] attack_rate;
  logic [RATE_W-1:0] decay_rate;
  logic [LVL_W-1:0]  sustain_lvl;
  logic [RATE_W-1:0] release_rate;
  logic [LVL_W-1:0]  env_scale;
  logic              env_dv;
  logic              env_active;

  modport master (
    output sample_rate, note_on, note_off, attack_rate, decay_rate, sustain_lvl, release_rate,
    input  env_scale, env_dv, env_active
  );

  modport slave (
    input  sample_rate, note_on, note_off, attack_rate, decay_rate, sustain_lvl, release_rate,
    output env_scale, env_dv, env_active
  );

endinterface

// File: rtl/adsr_envelope_rate_step.sv
// Saturating one-tick step of the envelope accumulator toward a clamp target.
module adsr_envelope_rate_step #(
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned RATE_W = 8
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [RATE_W-1:0] rate,
  input  logic [ACC_W-1:0]  target,
  input  logic              up,
  output logic [ACC_W-1:0]  acc_next,
  output logic              reached
);

  logic [ACC_W-1:0] rate_w;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W:0]   floor_ext;

  assign rate_w    = ACC_W'(rate);
  assign sum_ext   = {1'b0, acc} + {1'b0, rate_w};
  // acc - rate <= target rewritten as acc <= target + rate so nothing can underflow.
  assign floor_ext = {1'b0, target} + {1'b0, rate_w};

  always_comb begin
    if (rate == '0) begin
      reached = 1'b1;
    end else if (up) begin
      reached = (sum_ext >= {1'b0, target});
    end else begin
      reached = (floor_ext >= {1'b0, acc});
    end
  end

  assign acc_next = reached ? target : (up ? (acc + rate_w) : (acc - rate_w));

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: FSM plus level accumulator, stepping once per sample_rate strobe.
module adsr_envelope
  import adsr_envelope_pkg::*;
#(
  parameter int unsigned ACC_W  = ENV_ACC_W,
  parameter int unsigned LVL_W  = ENV_LVL_W,
  parameter int unsigned RATE_W = ENV_RATE_W
) (
  input logic            clk,
  input logic            rst,
  adsr_envelope_if.slave bus
);

  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam int unsigned      PAD_W   = ACC_W - LVL_W;

  env_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             env_dv_q, env_active_q;

  logic [ACC_W-1:0]  sus_tgt;
  logic              note_off_ok;
  logic              tick;
  logic              step_up;
  logic [RATE_W-1:0] step_rate;
  logic [ACC_W-1:0]  step_tgt;
  logic [ACC_W-1:0]  step_next;
  logic              step_reached;

  assign sus_tgt     = {bus.sustain_lvl, {PAD_W{1'b0}}};
  assign note_off_ok = bus.note_off && !bus.note_on && env_gated(state_q);
  // An ignored note_off does not steal the tick.
  assign tick        = bus.sample_rate && !bus.note_on && !note_off_ok;

  always_comb begin
    step_up   = 1'b0;
    step_rate = bus.release_rate;
    step_tgt  = '0;
    case (state_q)
      ENV_ATTACK: begin
        step_up   = 1'b1;
        step_rate = bus.attack_rate;
        step_tgt  = ACC_MAX;
      end
      ENV_DECAY: begin
        step_rate = bus.decay_rate;
        step_tgt  = sus_tgt;
      end
      default: ;
    endcase
  end

  adsr_envelope_rate_step #(
    .ACC_W  (ACC_W),
    .RATE_W (RATE_W)
  ) u_rate_step (
    .acc      (acc_q),
    .rate     (step_rate),
    .target   (step_tgt),
    .up       (step_up),
    .acc_next (step_next),
    .reached  (step_reached)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    if (bus.note_on) begin
      state_d = ENV_ATTACK;
    end else if (note_off_ok) begin
      state_d = ENV_RELEASE;
    end else if (bus.sample_rate) begin
      case (state_q)
        ENV_IDLE: acc_d = '0;
        ENV_ATTACK: begin
          acc_d = step_next;
          if (step_reached) state_d = ENV_DECAY;
        end
        ENV_DECAY: begin
          acc_d = step_next;
          if (step_reached) state_d = ENV_SUSTAIN;
        end
        ENV_SUSTAIN: acc_d = sus_tgt;
        ENV_RELEASE: begin
          acc_d = step_next;
          if (step_reached) state_d = ENV_IDLE;
        end
        default: begin
          state_d = ENV_IDLE;
          acc_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ENV_IDLE;
      acc_q        <= '0;
      env_dv_q     <= 1'b0;
      env_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      env_dv_q     <= tick;
      env_active_q <= (state_d != ENV_IDLE);
    end
  end

  assign bus.env_scale  = acc_q[ACC_W-1 -: LVL_W];
  assign bus.env_dv     = env_dv_q;
  assign bus.env_active = env_active_q;

endmodule
